// File: rtl/xor_share_arbiter.sv
`default_nettype none
// =============================================================================
// Module : xor_share_arbiter
// Round-robin shared a^b datapath with one registered, id-tagged output stage.
// Optional macro XOR_ARB_LOCK_EN adds a lock input that pins priority.
// Rev    : 1.0
// =============================================================================
module xor_share_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
`ifdef XOR_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [IDW:0]   c_nreq = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] c_last = IDW'(NREQ-1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   r_data;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_start;
  logic [IDW:0]   w_idx;
  logic [IDW-1:0] w_win;
  logic           w_found;
  logic           w_can_issue;
  logic           w_fire;
  logic [N-1:0]   w_res;

`ifdef XOR_ARB_LOCK_EN
  logic r_locked;

  // A locked winner keeps first place in the search until it is granted unlocked.
  always_comb begin
    if (r_locked)
      w_start = r_ptr;
    else if (r_ptr == c_last)
      w_start = '0;
    else
      w_start = r_ptr + 1'b1;
  end
`else
  always_comb begin
    if (r_ptr == c_last)
      w_start = '0;
    else
      w_start = r_ptr + 1'b1;
  end
`endif

  // Rotating first-set search, modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, w_start} + (IDW+1)'(i);
      if (w_idx >= c_nreq)
        w_idx = w_idx - c_nreq;
      if (!w_found && req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  // Only the granted lane is selected, so unrequested lanes never reach the result.
  assign w_res = a_in[w_win*N +: N] ^ b_in[w_win*N +: N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    w_can_issue = (r_state == ST_EMPTY) || res_ready;
    w_fire      = w_can_issue && w_found && rst_n;
    if (w_fire)
      gnt[w_win] = 1'b1;
    case (r_state)
      ST_EMPTY: if (w_fire) w_state_nxt = ST_FULL;
      ST_FULL:  if (res_ready) w_state_nxt = w_fire ? ST_FULL : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= c_last;
      r_data   <= '0;
      r_id     <= '0;
`ifdef XOR_ARB_LOCK_EN
      r_locked <= 1'b0;
`endif
    end else if (w_fire) begin
      r_ptr    <= w_win;
      r_data   <= w_res;
      r_id     <= w_win;
`ifdef XOR_ARB_LOCK_EN
      r_locked <= lock[w_win];
`endif
    end
  end

  assign res_valid = (r_state == ST_FULL);
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign busy      = res_valid | (|req);

endmodule
`default_nettype wire

// File: tb/tb_xor_share_arbiter.sv
`default_nettype none
// =============================================================================
// Module : tb_xor_share_arbiter
// Directed self-checking bench for xor_share_arbiter (N=16, NREQ=4).
// Rev    : 1.0
// =============================================================================
module tb_xor_share_arbiter;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   lock = '0;
  logic [NREQ*N-1:0] a_in = '0;
  logic [NREQ*N-1:0] b_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [N-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  xor_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef XOR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    a_in[i*N +: N] = a;
    b_in[i*N +: N] = b;
  endtask

  // Lane operands used while several requesters are active.
  function automatic logic [N-1:0] lane_a(input int k);
    return 16'(16'h1111 * (k + 1));
  endfunction

  function automatic logic [N-1:0] lane_b(input int k);
    return 16'h0F0F ^ 16'(k);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] hold;
    int k;

    // Reset state, with a pending request that must not be granted
    req = 4'b0001;
    #12;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data",  32'(res_data),  32'd0);
    chk("rst_id",    32'(res_id),    32'd0);
    chk("rst_gnt",   32'(gnt),       32'd0);
    tick();
    rst_n = 1'b1;

    // Single request, first grant goes to requester 0
    set_lane(0, 16'hA5A5, 16'h0F0F);
    #1 chk("t1_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_data",  32'(res_data),  32'hAAAA);
    chk("t1_id",    32'(res_id),    32'd0);

    // All four requesting: round-robin from rr_ptr=0, one result per cycle
    for (int i = 0; i < NREQ; i++) set_lane(i, lane_a(i), lane_b(i));
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      k = (1 + j) % NREQ;
      #1 chk("t2_gnt", 32'(gnt), 32'(1 << k));
      tick();
      chk("t2_valid", 32'(res_valid), 32'd1);
      chk("t2_id",    32'(res_id),    32'(k));
      chk("t2_data",  32'(res_data),  32'(lane_a(k) ^ lane_b(k)));
    end

    // Backpressure: FULL holding requester 0's result
    hold = lane_a(0) ^ lane_b(0);
    res_ready = 1'b0;
    req = 4'b0110;
    for (int j = 0; j < 3; j++) begin
      #1 chk("t3_gnt_stall", 32'(gnt), 32'd0);
      tick();
      chk("t3_valid", 32'(res_valid), 32'd1);
      chk("t3_hold",  32'(res_data),  32'(hold));
      chk("t3_id",    32'(res_id),    32'd0);
    end
    res_ready = 1'b1;
    #1 chk("t3_gnt_resume", 32'(gnt), 32'b0010);
    tick();
    chk("t3_id_resume",   32'(res_id),   32'd1);
    chk("t3_data_resume", 32'(res_data), 32'(lane_a(1) ^ lane_b(1)));

    // Asynchronous reset while FULL
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_valid", 32'(res_valid), 32'd0);
    chk("t4_async_gnt",   32'(gnt),       32'd0);
    tick();
    rst_n = 1'b1;
    req = 4'b1000;
    #1 chk("t4_gnt", 32'(gnt), 32'b1000);
    tick();
    chk("t4_valid", 32'(res_valid), 32'd1);
    chk("t4_id",    32'(res_id),    32'd3);
    chk("t4_data",  32'(res_data),  32'(lane_a(3) ^ lane_b(3)));

    // Data patterns with unrequested lanes undriven-X
    a_in = 'x;
    b_in = 'x;
    set_lane(0, 16'hFFFF, 16'hFFFF);
    req = 4'b0001;
    #1 chk("t5_gnt_a", 32'(gnt), 32'b0001);
    tick();
    chk("t5_ones",  32'(res_data), 32'h0000);
    set_lane(0, 16'h0000, 16'h1234);
    #1 chk("t5_gnt_single", 32'(gnt), 32'b0001);
    tick();
    chk("t5_pass",  32'(res_data), 32'h1234);
    a_in = 'x;
    b_in = 'x;
    set_lane(2, 16'h5A5A, 16'h00FF);
    req = 4'b0100;
    #1 chk("t5_gnt_c", 32'(gnt), 32'b0100);
    tick();
    chk("t5_xlane", 32'(res_data), 32'h5AA5);
    chk("t5_id",    32'(res_id),   32'd2);

    // Drain: FULL with ready and no request returns to EMPTY
    req = 4'b0000;
    #1;
    chk("drain_gnt",  32'(gnt),  32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    tick();
    chk("drain_valid", 32'(res_valid), 32'd0);
    chk("drain_idle",  32'(busy),      32'd0);
    chk("drain_hold",  32'(res_data),  32'h5AA5);

`ifdef XOR_ARB_LOCK_EN
    // Lock pins requester 0, then release returns to alternation
    for (int i = 0; i < NREQ; i++) set_lane(i, lane_a(i), lane_b(i));
    req  = 4'b0001;
    lock = 4'b0001;
    #1 chk("t6_gnt_first", 32'(gnt), 32'b0001);
    tick();
    req = 4'b0011;
    for (int j = 0; j < 3; j++) begin
      #1 chk("t6_gnt_locked", 32'(gnt), 32'b0001);
      tick();
      chk("t6_id_locked", 32'(res_id), 32'd0);
    end
    lock = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      #1 chk("t6_gnt_rr", 32'(gnt), (j % 2 == 0) ? 32'b0001 : 32'b0010);
      tick();
    end
    req = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
